// File: rtl/regfile_wb_scoreboard.sv
// Register-file writeback controller: per-register pending-write scoreboard with
// issue hazard stall, plus a round-robin arbiter for the single write port.
module regfile_wb_scoreboard #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          res,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rs1,
  input  logic [AW-1:0] issue_rs2,
  input  logic          issue_use_rs1,
  input  logic          issue_use_rs2,
  input  logic [AW-1:0] issue_rd,
  input  logic          issue_rd_we,
  output logic          issue_stall,
  input  logic          alu_wb_valid,
  input  logic [AW-1:0] alu_wb_rd,
  input  logic [DW-1:0] alu_wb_data,
  output logic          alu_wb_ready,
  input  logic          mem_wb_valid,
  input  logic [AW-1:0] mem_wb_rd,
  input  logic [DW-1:0] mem_wb_data,
  output logic          mem_wb_ready,
  output logic          reg_write,
  output logic [AW-1:0] write_reg,
  output logic [DW-1:0] write_data,
  output logic          idle,
  output logic          err_spurious
);

  localparam int NR = 2 ** AW;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_t;

  src_t          rr_last;
  src_t          rr_next;
  logic [NR-1:0] busy;
  logic [NR-1:0] clr_vec;
  logic [NR-1:0] set_vec;
  logic [NR-1:0] eff_busy;
  logic          alu_grant;
  logic          mem_grant;
  logic          issue_accept;

  // On contention the source that did not win last time gets the port.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    rr_next   = rr_last;
    if (alu_wb_valid && mem_wb_valid) begin
      alu_grant = (rr_last == SRC_MEM);
      mem_grant = (rr_last == SRC_ALU);
    end else begin
      alu_grant = alu_wb_valid;
      mem_grant = mem_wb_valid;
    end
    if (alu_grant) begin
      rr_next = SRC_ALU;
    end else if (mem_grant) begin
      rr_next = SRC_MEM;
    end
  end

  assign alu_wb_ready = alu_grant;
  assign mem_wb_ready = mem_grant;
  assign reg_write    = alu_grant | mem_grant;

  always_comb begin
    write_reg  = '0;
    write_data = '0;
    if (alu_grant) begin
      write_reg  = alu_wb_rd;
      write_data = alu_wb_data;
    end else if (mem_grant) begin
      write_reg  = mem_wb_rd;
      write_data = mem_wb_data;
    end
  end

  // Register 0 is hardwired, so it never enters the scoreboard.
  genvar gi;
  generate
    for (gi = 0; gi < NR; gi++) begin : g_vec
      if (gi == 0) begin : g_zero
        assign clr_vec[gi] = 1'b0;
        assign set_vec[gi] = 1'b0;
      end else begin : g_reg
        assign clr_vec[gi] = reg_write && (write_reg == AW'(gi));
        assign set_vec[gi] = issue_accept && issue_rd_we && (issue_rd == AW'(gi));
      end
    end
  endgenerate

  // Clearing in the writeback cycle mirrors the register file's write-through.
  assign eff_busy = busy & ~clr_vec;

  assign issue_stall = issue_valid &&
                       ((issue_use_rs1 && eff_busy[issue_rs1]) ||
                        (issue_use_rs2 && eff_busy[issue_rs2]) ||
                        (issue_rd_we   && eff_busy[issue_rd]));
  assign issue_accept = issue_valid && !issue_stall;

  assign idle = (busy == '0);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      busy         <= '0;
      rr_last      <= SRC_MEM;
      err_spurious <= 1'b0;
    end else begin
      busy    <= eff_busy | set_vec;
      rr_last <= rr_next;
      if (reg_write && (write_reg != '0) && !busy[write_reg]) begin
        err_spurious <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Scenario bench for regfile_wb_scoreboard: expected writebacks are queued when
// requests are driven and popped when the write port fires.
module tb_regfile_wb_scoreboard;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          res;
  logic          issue_valid, issue_use_rs1, issue_use_rs2, issue_rd_we;
  logic [AW-1:0] issue_rs1, issue_rs2, issue_rd;
  logic          issue_stall;
  logic          alu_wb_valid, mem_wb_valid;
  logic [AW-1:0] alu_wb_rd, mem_wb_rd;
  logic [DW-1:0] alu_wb_data, mem_wb_data;
  logic          alu_wb_ready, mem_wb_ready;
  logic          reg_write;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic          idle, err_spurious;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_t;

  wb_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  always #5 clk = ~clk;

  regfile_wb_scoreboard #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .res(res),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_stall(issue_stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .mem_wb_ready(mem_wb_ready),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .idle(idle), .err_spurious(err_spurious)
  );

  // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid = 0; issue_use_rs1 = 0; issue_use_rs2 = 0; issue_rd_we = 0;
    issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    alu_wb_valid = 0; alu_wb_rd = '0; alu_wb_data = '0;
    mem_wb_valid = 0; mem_wb_rd = '0; mem_wb_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    res = 1'b0;
    step();
    step();
    res = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    res = 1'b0;
    #3;
    step();
    res = 1'b1;
    #2;
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle got=%b exp=1", idle); end
    n_cmp++; if (issue_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", issue_stall); end
    n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL reset_reg_write got=%b exp=0", reg_write); end
    n_cmp++; if (err_spurious !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err_spurious); end
    step();
    issue_valid = 1; issue_rd = 5; issue_rd_we = 1;
    step();
    clear_inputs();
    #2;
    n_cmp++; if (idle !== 1'b0) begin n_bad++; $display("FAIL busy5_set_idle got=%b exp=0", idle); end
    res = 1'b0;
    #1;
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL midreset_idle got=%b exp=1", idle); end
    n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL midreset_reg_write got=%b exp=0", reg_write); end
    step();
    res = 1'b1;
    issue_valid = 1; issue_rs1 = 5; issue_use_rs1 = 1;
    #2;
    n_cmp++; if (issue_stall !== 1'b0) begin n_bad++; $display("FAIL post_reset_read_x5 got=%b exp=0", issue_stall); end
    $display("reset: mid-stream reset cleared busy[5]; x5 reader stall=%b", issue_stall);
    step();
    clear_inputs();
  endtask

  task automatic test_raw_bypass();
    wb_t e;
    issue_valid = 1; issue_rd = 3; issue_rd_we = 1;
    #2;
    n_cmp++; if (issue_stall !== 1'b0) begin n_bad++; $display("FAIL raw_issue_rd3 got=%b exp=0", issue_stall); end
    step();
    clear_inputs();
    issue_valid = 1; issue_rs1 = 3; issue_use_rs1 = 1;
    #2;
    n_cmp++; if (issue_stall !== 1'b1) begin n_bad++; $display("FAIL raw_stall got=%b exp=1", issue_stall); end
    step();
    alu_wb_valid = 1; alu_wb_rd = 3; alu_wb_data = 32'hDEADBEEF;
    sb_q.push_back('{rd: 5'd3, data: 32'hDEADBEEF});
    #2;
    n_cmp++; if (issue_stall !== 1'b0) begin n_bad++; $display("FAIL raw_bypass_stall got=%b exp=0", issue_stall); end
    n_cmp++; if (reg_write !== 1'b1) begin n_bad++; $display("FAIL raw_reg_write got=%b exp=1", reg_write); end
    e = sb_q.pop_front();
    n_cmp++; if (write_reg !== e.rd) begin n_bad++; $display("FAIL raw_write_reg got=%0d exp=%0d", write_reg, e.rd); end
    n_cmp++; if (write_data !== e.data) begin n_bad++; $display("FAIL raw_write_data got=%h exp=%h", write_data, e.data); end
    $display("raw: wb rd=%0d data=%h stall=%b", write_reg, write_data, issue_stall);
    step();
    clear_inputs();
    issue_valid = 1; issue_rs1 = 3; issue_use_rs1 = 1;
    #2;
    n_cmp++; if (issue_stall !== 1'b0) begin n_bad++; $display("FAIL raw_after_clear_stall got=%b exp=0", issue_stall); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL raw_after_clear_idle got=%b exp=1", idle); end
    n_cmp++; if ({reg_write, write_reg, write_data} !== '0) begin
      n_bad++; $display("FAIL idle_port got=%b/%0d/%h exp=0/0/0", reg_write, write_reg, write_data);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    wb_t e;
    int  alu_cnt;
    int  mem_cnt;
    logic exp_alu;
    alu_cnt = 0;
    mem_cnt = 0;
    do_reset();
    issue_valid = 1; issue_rd = 1; issue_rd_we = 1;
    step();
    issue_rd = 2;
    step();
    clear_inputs();
    for (int i = 0; i < 8; i++) begin
      alu_wb_valid = 1; alu_wb_rd = 1; alu_wb_data = 32'hA000_0000 + DW'(alu_cnt);
      mem_wb_valid = 1; mem_wb_rd = 2; mem_wb_data = 32'hB000_0000 + DW'(mem_cnt);
      exp_alu = (i % 2 == 0);
      if (exp_alu) sb_q.push_back('{rd: 5'd1, data: 32'hA000_0000 + DW'(alu_cnt)});
      else         sb_q.push_back('{rd: 5'd2, data: 32'hB000_0000 + DW'(mem_cnt)});
      #2;
      n_cmp++; if (alu_wb_ready !== exp_alu) begin n_bad++; $display("FAIL rr_alu_ready[%0d] got=%b exp=%b", i, alu_wb_ready, exp_alu); end
      n_cmp++; if (mem_wb_ready !== !exp_alu) begin n_bad++; $display("FAIL rr_mem_ready[%0d] got=%b exp=%b", i, mem_wb_ready, !exp_alu); end
      e = sb_q.pop_front();
      n_cmp++; if (write_reg !== e.rd || write_data !== e.data) begin
        n_bad++; $display("FAIL rr_port[%0d] got=%0d/%h exp=%0d/%h", i, write_reg, write_data, e.rd, e.data);
      end
      $display("rr: cycle %0d alu_ready=%b mem_ready=%b rd=%0d data=%h", i, alu_wb_ready, mem_wb_ready, write_reg, write_data);
      if (alu_wb_ready) alu_cnt++;
      if (mem_wb_ready) mem_cnt++;
      step();
    end
    clear_inputs();
    #2;
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL rr_idle_after got=%b exp=1", idle); end
    step();
  endtask

  task automatic test_set_wins();
    wb_t e;
    issue_valid = 1; issue_rd = 7; issue_rd_we = 1;
    step();
    mem_wb_valid = 1; mem_wb_rd = 7; mem_wb_data = 32'h0000_0077;
    sb_q.push_back('{rd: 5'd7, data: 32'h0000_0077});
    #2;
    n_cmp++; if (issue_stall !== 1'b0) begin n_bad++; $display("FAIL waw_stall got=%b exp=0", issue_stall); end
    n_cmp++; if (mem_wb_ready !== 1'b1) begin n_bad++; $display("FAIL waw_mem_ready got=%b exp=1", mem_wb_ready); end
    e = sb_q.pop_front();
    n_cmp++; if (write_reg !== e.rd || write_data !== e.data) begin
      n_bad++; $display("FAIL waw_port got=%0d/%h exp=%0d/%h", write_reg, write_data, e.rd, e.data);
    end
    step();
    clear_inputs();
    issue_valid = 1; issue_rs1 = 7; issue_use_rs1 = 1;
    #2;
    n_cmp++; if (issue_stall !== 1'b1) begin n_bad++; $display("FAIL waw_reader_stall got=%b exp=1", issue_stall); end
    n_cmp++; if (idle !== 1'b0) begin n_bad++; $display("FAIL waw_busy7 got idle=%b exp=0", idle); end
    $display("waw: set beat clear on x7, reader stall=%b", issue_stall);
    step();
    clear_inputs();
    mem_wb_valid = 1; mem_wb_rd = 7; mem_wb_data = 32'h0000_0078;
    step();
    clear_inputs();
    #2;
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL waw_drain_idle got=%b exp=1", idle); end
    step();
  endtask

  task automatic test_x0_spurious();
    wb_t e;
    do_reset();
    issue_valid = 1; issue_rd = 0; issue_rd_we = 1;
    #2;
    n_cmp++; if (issue_stall !== 1'b0) begin n_bad++; $display("FAIL x0_issue_stall got=%b exp=0", issue_stall); end
    step();
    clear_inputs();
    #2;
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL x0_idle got=%b exp=1", idle); end
    alu_wb_valid = 1; alu_wb_rd = 0; alu_wb_data = 32'h0000_1234;
    sb_q.push_back('{rd: 5'd0, data: 32'h0000_1234});
    #1;
    n_cmp++; if (reg_write !== 1'b1) begin n_bad++; $display("FAIL x0_reg_write got=%b exp=1", reg_write); end
    e = sb_q.pop_front();
    n_cmp++; if (write_reg !== e.rd || write_data !== e.data) begin
      n_bad++; $display("FAIL x0_port got=%0d/%h exp=%0d/%h", write_reg, write_data, e.rd, e.data);
    end
    step();
    alu_wb_rd = 9; alu_wb_data = 32'h0000_0099;
    #2;
    n_cmp++; if (err_spurious !== 1'b0) begin n_bad++; $display("FAIL x0_no_err got=%b exp=0", err_spurious); end
    step();
    clear_inputs();
    #2;
    n_cmp++; if (err_spurious !== 1'b1) begin n_bad++; $display("FAIL spurious_err got=%b exp=1", err_spurious); end
    step();
    #2;
    n_cmp++; if (err_spurious !== 1'b1) begin n_bad++; $display("FAIL spurious_sticky got=%b exp=1", err_spurious); end
    $display("x0: write to x0 ok, spurious write to x9 flagged err=%b", err_spurious);
    step();
  endtask

  initial begin
    clear_inputs();
    res = 1'b0;
    test_reset();
    test_raw_bypass();
    test_round_robin();
    test_set_wins();
    test_x0_spurious();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
